// File: rtl/lcd_ram_scanner.sv
// Scans NUM_CHARS words of display RAM and streams the low bytes to an LCD
// driver as printable characters over a valid/ready handshake.
module lcd_ram_scanner #(
    parameter int          DATA_WIDTH    = 32,
    parameter int          ADDRESS_WIDTH = 12,
    parameter int unsigned BASE_ADDR     = 0,
    parameter int          NUM_CHARS     = 32,
    parameter int          AUTO_REFRESH  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     ramWEn,
    output logic [ADDRESS_WIDTH-1:0] lcdOutAddr,
    input  logic [DATA_WIDTH-1:0]    lcdDataOut,
    output logic [7:0]               char_data,
    output logic [4:0]               char_pos,
    output logic                     char_valid,
    input  logic                     char_ready,
    output logic                     busy,
    output logic                     frame_done
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_SEND    = 2'd3;

    localparam logic [4:0]               LAST_INDEX = 5'(NUM_CHARS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] BASE       = ADDRESS_WIDTH'(BASE_ADDR);
    localparam logic [7:0]               BLANK      = 8'h20;

    logic [1:0]               state_reg, state_next;
    logic [4:0]               index_reg, index_next;
    logic [ADDRESS_WIDTH-1:0] addr_reg, addr_next;
    logic [7:0]               data_reg, data_next;
    logic [4:0]               pos_reg, pos_next;
    logic                     valid_reg, valid_next;
    logic                     busy_reg, busy_next;
    logic                     done_reg, done_next;

    logic [7:0] ram_byte;
    logic [7:0] shown_byte;

    assign ram_byte = lcdDataOut[7:0];

    // Only the low byte carries the character; upper bits of the word are ignored.
    generate
        if (DATA_WIDTH > 8) begin : g_upper
            logic unused_upper;
            assign unused_upper = ^lcdDataOut[DATA_WIDTH-1:8];
        end
    endgenerate

    // Control codes and DEL/high bytes are shown as blanks on the panel.
    assign shown_byte = ((ram_byte >= 8'h20) && (ram_byte <= 8'h7E)) ? ram_byte : BLANK;

    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        pos_next   = pos_reg;
        valid_next = valid_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    index_next = 5'd0;
                    addr_next  = BASE;
                    busy_next  = 1'b1;
                    state_next = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // The RAM output register only advances while no write is in progress.
                if (!ramWEn) begin
                    state_next = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                data_next  = shown_byte;
                pos_next   = index_reg;
                valid_next = 1'b1;
                state_next = ST_SEND;
            end

            ST_SEND: begin
                if (char_ready) begin
                    valid_next = 1'b0;
                    if (index_reg == LAST_INDEX) begin
                        done_next = 1'b1;
                        if (AUTO_REFRESH != 0) begin
                            index_next = 5'd0;
                            addr_next  = BASE;
                            state_next = ST_ISSUE;
                        end else begin
                            busy_next  = 1'b0;
                            state_next = ST_IDLE;
                        end
                    end else begin
                        index_next = index_reg + 5'd1;
                        addr_next  = BASE + ADDRESS_WIDTH'(index_reg + 5'd1);
                        state_next = ST_ISSUE;
                    end
                end
            end

            default: begin
                valid_next = 1'b0;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            index_reg <= 5'd0;
            addr_reg  <= BASE;
            data_reg  <= BLANK;
            pos_reg   <= 5'd0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            pos_reg   <= pos_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign lcdOutAddr = addr_reg;
    assign char_data  = data_reg;
    assign char_pos   = pos_reg;
    assign char_valid = valid_reg;
    assign busy       = busy_reg;
    assign frame_done = done_reg;

endmodule

// File: tb/tb_lcd_ram_scanner.sv
// Directed bench for lcd_ram_scanner: a RAM model with registered read feeds two
// instances (plain and auto-refresh/wrapping); a scoreboard checks the char stream.
module tb_lcd_ram_scanner;

    logic        clk = 1'b0;
    logic        reset, start, ramWEn, char_ready;
    logic [11:0] lcdOutAddr;
    logic [31:0] lcd_data;
    logic [7:0]  char_data;
    logic [4:0]  char_pos;
    logic        char_valid, busy, frame_done;

    logic        reset2, start2, ramWEn2, char_ready2;
    logic [11:0] lcdOutAddr2;
    logic [31:0] lcd_data2;
    logic [7:0]  char_data2;
    logic [4:0]  char_pos2;
    logic        char_valid2, busy2, frame_done2;

    logic [31:0] ram [0:4095];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_cnt2 = 0;
    int exp_done = 0;
    int cyc = 0;
    int last_cyc = 0;
    bit spacing_en = 1'b0;
    bit have_last = 1'b0;

    logic [12:0] q1[$];
    logic [12:0] q2[$];

    lcd_ram_scanner #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(12), .BASE_ADDR(0), .NUM_CHARS(32), .AUTO_REFRESH(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .ramWEn(ramWEn),
        .lcdOutAddr(lcdOutAddr), .lcdDataOut(lcd_data),
        .char_data(char_data), .char_pos(char_pos), .char_valid(char_valid),
        .char_ready(char_ready), .busy(busy), .frame_done(frame_done)
    );

    lcd_ram_scanner #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(12), .BASE_ADDR(32'hFF0), .NUM_CHARS(32), .AUTO_REFRESH(1)
    ) dut2 (
        .clk(clk), .reset(reset2), .start(start2), .ramWEn(ramWEn2),
        .lcdOutAddr(lcdOutAddr2), .lcdDataOut(lcd_data2),
        .char_data(char_data2), .char_pos(char_pos2), .char_valid(char_valid2),
        .char_ready(char_ready2), .busy(busy2), .frame_done(frame_done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Display RAM read port: output register holds while a write is in progress.
    always @(posedge clk) begin
        if (!ramWEn)  lcd_data  <= ram[lcdOutAddr];
        if (!ramWEn2) lcd_data2 <= ram[lcdOutAddr2];
    end

    function automatic logic [7:0] exp_char(input logic [31:0] w);
        logic [7:0] b;
        b = w[7:0];
        return ((b >= 8'h20) && (b <= 8'h7E)) ? b : 8'h20;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame1();
        for (int i = 0; i < 32; i++) q1.push_back({5'(i), exp_char(ram[12'(i)])});
    endtask

    task automatic push_frame2();
        logic [11:0] a;
        for (int i = 0; i < 32; i++) begin
            a = 12'(32'hFF0 + i);
            q2.push_back({5'(i), exp_char(ram[a])});
        end
    endtask

    task automatic wait_pos1(input logic [4:0] p, input string tag);
        int n;
        n = 0;
        while (!(char_valid === 1'b1 && char_pos === p) && n < 400) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, (char_valid === 1'b1 && char_pos === p)}, 32'd1);
    endtask

    task automatic wait_pos2(input logic [4:0] p, input string tag);
        int n;
        n = 0;
        while (!(char_valid2 === 1'b1 && char_pos2 === p) && n < 400) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, (char_valid2 === 1'b1 && char_pos2 === p)}, 32'd1);
    endtask

    task automatic wait_done1(input string tag);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, frame_done}, 32'd1);
    endtask

    task automatic wait_done2(input string tag);
        int n;
        n = 0;
        while (frame_done2 !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, frame_done2}, 32'd1);
    endtask

    // Scoreboard for the plain instance: every accepted character pops one entry.
    always @(negedge clk) begin : mon1
        logic [12:0] e;
        if (!reset && char_valid && char_ready) begin
            $display("dut1 char pos=%0d data=%02h cyc=%0d", char_pos, char_data, cyc);
            if (q1.size() == 0) begin
                chk("sb1_unexpected_char", {27'd0, char_pos}, 32'hFFFF_FFFF);
            end else begin
                e = q1.pop_front();
                chk("sb1_pos", {27'd0, char_pos}, {27'd0, e[12:8]});
                chk("sb1_data", {24'd0, char_data}, {24'd0, e[7:0]});
            end
            if (spacing_en && have_last) chk("sb1_spacing", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            have_last = 1'b1;
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    // Scoreboard for the auto-refresh instance; also checks the wrapped read address.
    always @(negedge clk) begin : mon2
        logic [12:0] e;
        if (!reset2 && char_valid2 && char_ready2) begin
            $display("dut2 char pos=%0d data=%02h addr=%03h", char_pos2, char_data2, lcdOutAddr2);
            if (q2.size() == 0) begin
                chk("sb2_unexpected_char", {27'd0, char_pos2}, 32'hFFFF_FFFF);
            end else begin
                e = q2.pop_front();
                chk("sb2_pos", {27'd0, char_pos2}, {27'd0, e[12:8]});
                chk("sb2_data", {24'd0, char_data2}, {24'd0, e[7:0]});
                chk("sb2_addr", {20'd0, lcdOutAddr2}, {20'd0, 12'(12'hFF0 + {7'd0, e[12:8]})});
            end
        end
        if (frame_done2 === 1'b1) done_cnt2++;
    end

    initial begin
        string msg;
        msg = "HELLO FROM THE LCD RAM SCANNER!!";
        for (int i = 0; i < 4096; i++) ram[i] = 32'd0;
        for (int i = 0; i < 32; i++) ram[i] = {8'(i), 8'hA5, 8'h00, 8'(msg[i])};
        for (int i = 0; i < 16; i++) ram[12'hFF0 + i] = {16'hBEEF, 8'h00, 8'(8'h61 + i)};
        ram[12'hFF3] = 32'h0000_007F;
        ram[12'hFFF] = 32'h0000_0020;

        reset = 1'b1; start = 1'b0; ramWEn = 1'b0; char_ready = 1'b1;
        reset2 = 1'b1; start2 = 1'b0; ramWEn2 = 1'b0; char_ready2 = 1'b1;
        #1;
        chk("rst_async_state", {3'd0, busy, char_valid, frame_done, char_pos, char_data, lcdOutAddr},
            {3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h20, 12'h000});
        chk("rst2_addr", {20'd0, lcdOutAddr2}, 32'h0000_0FF0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("idle_no_start", {31'd0, busy}, 32'd0);

        // Frame 1: clean frame, latency and 3-cycle spacing.
        push_frame1();
        spacing_en = 1'b1;
        have_last = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("f1_issue", {18'd0, busy, char_valid, lcdOutAddr}, {18'd0, 1'b1, 1'b0, 12'h000});
        tick();
        chk("f1_capture_valid", {31'd0, char_valid}, 32'd0);
        tick();
        chk("f1_first_char", {18'd0, char_valid, char_pos, char_data}, {18'd0, 1'b1, 5'd0, 8'h48});
        wait_done1("f1_frame_done_timeout");
        tick();
        spacing_en = 1'b0;
        exp_done = 1;
        chk("f1_done_pulse_busy", {30'd0, frame_done, busy}, 32'd0);
        chk("f1_done_count", 32'(done_cnt), 32'(exp_done));
        chk("f1_queue_empty", 32'(q1.size()), 32'd0);

        // Frame 2: non-printable mapping, ready back-pressure at 3, write stall at 5.
        ram[1] = 32'h0000_0007;
        ram[2] = 32'h0000_00FF;
        ram[3] = 32'h1234_5641;
        ram[6] = 32'h0000_007E;
        ram[7] = 32'h0000_007F;
        ram[8] = 32'h0000_001F;
        ram[9] = 32'hFFFF_FF20;
        push_frame1();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_pos1(5'd2, "f2_wait_pos2");
        tick();
        char_ready = 1'b0;
        wait_pos1(5'd3, "f2_wait_pos3");
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("f2_hold_pos3", {18'd0, char_valid, char_pos, char_data}, {18'd0, 1'b1, 5'd3, 8'h41});
        end
        char_ready = 1'b1;
        wait_pos1(5'd4, "f2_wait_pos4");
        tick();
        chk("f2_issue5_addr", {20'd0, lcdOutAddr}, 32'd5);
        ramWEn = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) start = 1'b0;
            chk("f2_stall5", {19'd0, char_valid, lcdOutAddr}, {19'd0, 1'b0, 12'd5});
        end
        ramWEn = 1'b0;
        tick();
        chk("f2_capture5", {31'd0, char_valid}, 32'd0);
        tick();
        chk("f2_send5", {18'd0, char_valid, char_pos, char_data}, {18'd0, 1'b1, 5'd5, 8'h20});
        wait_done1("f2_frame_done_timeout");
        tick();
        exp_done++;
        chk("f2_done_count", 32'(done_cnt), 32'(exp_done));
        chk("f2_busy_idle", {31'd0, busy}, 32'd0);

        // Frames 3 and 4: start held high restarts straight out of IDLE.
        push_frame1();
        push_frame1();
        start = 1'b1;
        wait_done1("f3_frame_done_timeout");
        tick();
        chk("f3_restart_busy", {30'd0, busy, frame_done}, {30'd0, 1'b1, 1'b0});
        wait_done1("f4_frame_done_timeout");
        start = 1'b0;
        tick();
        exp_done += 2;
        chk("f4_idle", {30'd0, busy, frame_done}, 32'd0);
        chk("f4_done_count", 32'(done_cnt), 32'(exp_done));
        chk("f4_queue_empty", 32'(q1.size()), 32'd0);

        // Frame 5: asynchronous reset while character 12 is on offer.
        push_frame1();
        char_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        char_ready = 1'b1;
        wait_pos1(5'd12, "f5_wait_pos12");
        #2;
        reset = 1'b1;
        #1;
        chk("f5_reset_async", {3'd0, busy, char_valid, frame_done, char_pos, char_data, lcdOutAddr},
            {3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h20, 12'h000});
        chk("f5_chars_accepted", 32'(q1.size()), 32'd20);
        q1.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("f5_no_done_after_reset", 32'(done_cnt), 32'(exp_done));
        chk("f5_stays_idle", {31'd0, busy}, 32'd0);

        // Frame 6: first post-reset frame restarts at character 0.
        push_frame1();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("f6_issue_addr0", {19'd0, busy, lcdOutAddr}, {19'd0, 1'b1, 12'h000});
        wait_done1("f6_frame_done_timeout");
        tick();
        exp_done++;
        chk("f6_done_count", 32'(done_cnt), 32'(exp_done));
        chk("f6_queue_empty", 32'(q1.size()), 32'd0);

        // Auto-refresh instance: base 0xFF0 wraps to 0x000, second frame starts unprompted.
        reset2 = 1'b0;
        tick();
        push_frame2();
        push_frame2();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("a1_issue_base", {19'd0, busy2, lcdOutAddr2}, {19'd0, 1'b1, 12'hFF0});
        wait_pos2(5'd16, "a1_wait_pos16");
        chk("a1_wrap_addr", {20'd0, lcdOutAddr2}, 32'd0);
        wait_done2("a1_frame_done_timeout");
        chk("a1_refresh_addr", {20'd0, lcdOutAddr2}, 32'h0000_0FF0);
        tick();
        chk("a1_refresh_busy", {30'd0, busy2, frame_done2}, {30'd0, 1'b1, 1'b0});
        chk("a1_done_count", 32'(done_cnt2), 32'd1);
        wait_done2("a2_frame_done_timeout");
        tick();
        reset2 = 1'b1;
        tick();
        chk("a2_done_count", 32'(done_cnt2), 32'd2);
        chk("a2_queue_empty", 32'(q2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_ram_scanner.md
LCD_RAM_SCANNER -- requirements
Module: lcd_ram_scanner

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning RAM word width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 12, meaning RAM address width.
REQ-003 The block SHALL have parameter BASE_ADDR, default 0, meaning RAM address of character 0.
REQ-004 The block SHALL have parameter NUM_CHARS, default 32, meaning characters per frame (16x2 LCD).
REQ-005 The block SHALL have parameter AUTO_REFRESH, default 0, meaning 1 restarts a frame immediately after frame end.
REQ-006 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-007 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 The block SHALL have port start, input, 1, request one frame scan (level sampled in IDLE).
REQ-009 The block SHALL have port ramWEn, input, 1, copy of the RAM write enable; lcdDataOut only updates on edges where it is 0.
REQ-010 The block SHALL have port lcdOutAddr, output, ADDRESS_WIDTH, RAM display read address.
REQ-011 The block SHALL have port lcdDataOut, input, DATA_WIDTH, RAM display read data, registered in RAM.
REQ-012 The block SHALL have port char_data, output, 8, character to LCD driver.
REQ-013 The block SHALL have port char_pos, output, 5, index of char_data within frame (0..NUM_CHARS-1).
REQ-014 The block SHALL have port char_valid, output, 1, char_data/char_pos valid.
REQ-015 The block SHALL have port char_ready, input, 1, LCD driver accepts character.
REQ-016 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-017 The block SHALL have port frame_done, output, 1, one-cycle pulse after last character accepted.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, CAPTURE, SEND; all outputs registered.
REQ-019 In IDLE with start=1 at an edge, the block SHALL set index=0, lcdOutAddr=BASE_ADDR, enter ISSUE.
REQ-020 In ISSUE, lcdOutAddr SHALL equal BASE_ADDR+index (truncated to ADDRESS_WIDTH, wraps modulo 2^ADDRESS_WIDTH).
REQ-021 ISSUE SHALL advance to CAPTURE only on an edge where ramWEn=0; otherwise it SHALL remain in ISSUE (stall, no data taken).
REQ-022 In CAPTURE, the block SHALL register lcdDataOut[7:0] into char_data, mapping values outside 0x20..0x7E to 0x20, set char_pos=index, char_valid=1, enter SEND.
REQ-023 Minimum latency: start edge -> char_valid high 2 cycles later (ISSUE 1 cycle, CAPTURE 1 cycle).
REQ-024 In SEND, char_valid, char_data, char_pos SHALL stay stable until an edge with char_ready=1 (handshake).
REQ-025 On handshake with index<NUM_CHARS-1: char_valid->0, index+1, lcdOutAddr updated, enter ISSUE.
REQ-026 On handshake with index=NUM_CHARS-1: char_valid->0, frame_done=1 for exactly the next cycle; enter IDLE if AUTO_REFRESH=0, else ISSUE with index=0.
REQ-027 start while busy SHALL be ignored; start held high in IDLE SHALL begin a new frame each time IDLE is reached.
REQ-028 char_ready while char_valid=0 SHALL have no effect.
REQ-029 Index counter width SHALL be 5 bits minimum; NUM_CHARS SHALL be 1..32.

Reset
REQ-030 Reset assertion SHALL immediately (asynchronously) force IDLE, index=0, lcdOutAddr=BASE_ADDR, char_data=0x20, char_pos=0, char_valid=0, busy=0, frame_done=0.
REQ-031 Reset mid-frame SHALL abandon the frame with no frame_done; first post-reset frame starts at index 0.

Verification
REQ-032 RAM[0..31]="HELLO..." ASCII, ramWEn=0, char_ready=1, start pulse -> 32 characters in order, char_pos 0..31, each 3 cycles apart, frame_done once.
REQ-033 ramWEn=1 for 4 cycles while in ISSUE for index 5 -> ISSUE held 4 extra cycles, char 5 still the correct RAM[5] value.
REQ-034 char_ready=0 for 10 cycles during SEND of index 3 -> char_valid, char_data, char_pos unchanged for all 10 cycles, no skipped/duplicated character.
REQ-035 RAM word 0x00000007 and 0x000000FF -> char_data=0x20; word 0x12345641 -> char_data=0x41.
REQ-036 Reset asserted mid-frame at index 12 between clock edges -> char_valid and busy 0 before next edge; next start begins at char_pos 0.
REQ-037 AUTO_REFRESH=1, BASE_ADDR=0xFF0, NUM_CHARS=32 -> addresses wrap 0xFFF->0x000, frame_done pulses, next frame starts without start.
